// File: rtl/alu_result_stage.sv
// alu_result_stage: execute-to-writeback stage behind the 16-bit ALU.
//
// Captures each completed ALU operation. It updates the {N,Z,C,V} status
// flags and resolves BNE branches into a one-cycle taken pulse. Register-file
// writebacks are buffered in a small FIFO so a stalled writeback port never
// drops an in-flight result.
//
// Handshake: a transfer happens on a rising edge where valid && ready. A
// producer holds its payload stable while valid=1 and ready=0. in_ready
// depends on registered state only.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         upstream handshake for one ALU operation
//   in_opcode, in_result,       ALU opcode and outputs (out, Cout, lt, eq, V)
//   in_cout, in_lt, in_eq, in_v
//   in_rd, in_wb_en             destination register and writeback enable
//   in_is_branch, in_br_target  BNE marker (compare in in_eq) and target
//   wb_valid / wb_ready         writeback FIFO head handshake
//   wb_rd, wb_data              FIFO head contents
//   br_taken, br_target         registered branch-taken pulse and its target
//   flags                       {N,Z,C,V} status register
//   op_count                    accepted-operation counter (wraps)
//   dbg_count                   current FIFO occupancy
module alu_result_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [15:0]      in_result,
    input  logic             in_cout,
    input  logic             in_lt,
    input  logic             in_eq,
    input  logic             in_v,
    input  logic [2:0]       in_rd,
    input  logic             in_wb_en,
    input  logic             in_is_branch,
    input  logic [15:0]      in_br_target,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [2:0]       wb_rd,
    output logic [15:0]      wb_data,
    output logic             br_taken,
    output logic [15:0]      br_target,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] op_count,
    output logic [$clog2(DEPTH):0] dbg_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [18:0]      mem_q [DEPTH];
    logic [18:0]      mem_d [DEPTH];
    logic [18:0]      last_q, last_d;       // last popped {rd,data}
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             br_taken_q, br_taken_d;
    logic [15:0]      br_target_q, br_target_d;

    logic empty, full, accept, push, pop, arith_op;
    logic [18:0] head;

    // in_lt is carried for completeness; SLT results arrive via in_result.
    logic unused_lt;
    assign unused_lt = in_lt;

    // Extra wrap bit distinguishes full from empty when indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && in_wb_en && !in_is_branch;
    assign pop      = !empty && wb_ready;
    assign arith_op = (in_opcode == 3'd2) || (in_opcode == 3'd6);
    assign head     = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        last_d      = last_q;
        flags_d     = flags_q;
        op_count_d  = op_count_q;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = {in_rd, in_result};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            last_d   = head;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (accept) begin
            op_count_d = op_count_q + CNT_ONE;
            if (in_is_branch) begin
                // BNE: taken when the compare reports not-equal.
                if (!in_eq) begin
                    br_taken_d  = 1'b1;
                    br_target_d = in_br_target;
                end
            end else begin
                flags_d[3] = in_result[15];
                flags_d[2] = (in_result == 16'h0000);
                if (arith_op) begin
                    flags_d[1] = in_cout;
                    flags_d[0] = in_v;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            last_q      <= '0;
            flags_q     <= '0;
            op_count_q  <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            last_q      <= last_d;
            flags_q     <= flags_d;
            op_count_q  <= op_count_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    // When empty, the outputs show the most recently popped entry.
    assign wb_valid  = !empty;
    assign wb_rd     = empty ? last_q[18:16] : head[18:16];
    assign wb_data   = empty ? last_q[15:0]  : head[15:0];
    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;
    assign flags     = flags_q;
    assign op_count  = op_count_q;
    assign dbg_count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_opcode = 3'd0;
    logic [15:0] in_result = 16'h0;
    logic        in_cout = 1'b0;
    logic        in_lt = 1'b0;
    logic        in_eq = 1'b0;
    logic        in_v = 1'b0;
    logic [2:0]  in_rd = 3'd0;
    logic        in_wb_en = 1'b0;
    logic        in_is_branch = 1'b0;
    logic [15:0] in_br_target = 16'h0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        br_taken;
    logic [15:0] br_target;
    logic [3:0]  flags;
    logic [15:0] op_count;
    logic [1:0]  dbg_count;

    // Second instance with a narrow counter for the wrap scenario.
    logic        c4_valid = 1'b0;
    logic        c4_ready, c4_wb_valid, c4_br_taken;
    logic [2:0]  c4_wb_rd;
    logic [15:0] c4_wb_data, c4_br_target;
    logic [3:0]  c4_flags;
    logic [3:0]  c4_op_count;
    logic [1:0]  c4_dbg_count;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_cnt = 16'h0;

    always #5 clk = ~clk;

    alu_result_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_result(in_result), .in_cout(in_cout),
        .in_lt(in_lt), .in_eq(in_eq), .in_v(in_v), .in_rd(in_rd),
        .in_wb_en(in_wb_en), .in_is_branch(in_is_branch),
        .in_br_target(in_br_target), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .br_taken(br_taken),
        .br_target(br_target), .flags(flags), .op_count(op_count),
        .dbg_count(dbg_count)
    );

    alu_result_stage #(.DEPTH(2), .CNT_W(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(c4_valid), .in_ready(c4_ready),
        .in_opcode(3'd0), .in_result(16'h0), .in_cout(1'b0),
        .in_lt(1'b0), .in_eq(1'b0), .in_v(1'b0), .in_rd(3'd0),
        .in_wb_en(1'b0), .in_is_branch(1'b0),
        .in_br_target(16'h0), .wb_valid(c4_wb_valid), .wb_ready(1'b1),
        .wb_rd(c4_wb_rd), .wb_data(c4_wb_data), .br_taken(c4_br_taken),
        .br_target(c4_br_target), .flags(c4_flags), .op_count(c4_op_count),
        .dbg_count(c4_dbg_count)
    );

    // Advance one edge, then settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [15:0] res,
                            input logic cout, input logic v,
                            input logic [2:0] rd, input logic wb_en);
        in_valid     = 1'b1;
        in_opcode    = op;
        in_result    = res;
        in_cout      = cout;
        in_v         = v;
        in_rd        = rd;
        in_wb_en     = wb_en;
        in_is_branch = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (wb_valid !== 1'b0 || wb_rd !== 3'd0 || wb_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_wb: valid=%b rd=%0d data=%h expected 0/0/0000", wb_valid, wb_rd, wb_data);
        end
        checks++;
        if (flags !== 4'b0000 || op_count !== 16'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: flags=%b cnt=%0d ready=%b expected 0000/0/1", flags, op_count, in_ready);
        end
        checks++;
        if (br_taken !== 1'b0 || br_target !== 16'h0) begin
            errors++;
            $display("FAIL reset_br: taken=%b target=%h expected 0/0000", br_taken, br_target);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_flags();
        drive_op(3'd2, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b0);
        step(); exp_cnt++;
        checks++;
        if (flags !== 4'b0110) begin
            errors++;
            $display("FAIL flags_add: got %b expected 0110", flags);
        end
        drive_op(3'd0, 16'h8000, 1'b0, 1'b0, 3'd1, 1'b0);
        step(); exp_cnt++;
        checks++;
        if (flags !== 4'b1010) begin
            errors++;
            $display("FAIL flags_and: got %b expected 1010", flags);
        end
        drive_op(3'd6, 16'h7FFF, 1'b0, 1'b1, 3'd1, 1'b0);
        step(); exp_cnt++;
        checks++;
        if (flags !== 4'b0001) begin
            errors++;
            $display("FAIL flags_sub: got %b expected 0001", flags);
        end
        // Reserved opcode: N,Z update, C,V hold.
        drive_op(3'd4, 16'h0000, 1'b1, 1'b0, 3'd1, 1'b0);
        step(); exp_cnt++;
        checks++;
        if (flags !== 4'b0101) begin
            errors++;
            $display("FAIL flags_rsvd: got %b expected 0101", flags);
        end
        in_valid = 1'b0;
        checks++;
        if (op_count !== exp_cnt || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flags_count: cnt=%0d wb_valid=%b expected %0d/0", op_count, wb_valid, exp_cnt);
        end
    endtask

    task automatic test_branch();
        drive_op(3'd6, 16'hFFFF, 1'b0, 1'b0, 3'd2, 1'b1);
        in_is_branch = 1'b1;
        in_eq        = 1'b0;
        in_br_target = 16'h0040;
        step(); exp_cnt++;
        in_valid = 1'b0;
        checks++;
        if (br_taken !== 1'b1 || br_target !== 16'h0040 || wb_valid !== 1'b0 || flags !== 4'b0101) begin
            errors++;
            $display("FAIL br_taken: taken=%b target=%h wbv=%b flags=%b expected 1/0040/0/0101",
                     br_taken, br_target, wb_valid, flags);
        end
        step();
        checks++;
        if (br_taken !== 1'b0 || br_target !== 16'h0040) begin
            errors++;
            $display("FAIL br_pulse: taken=%b target=%h expected 0/0040", br_taken, br_target);
        end
        in_valid     = 1'b1;
        in_eq        = 1'b1;
        in_br_target = 16'h1234;
        step(); exp_cnt++;
        in_valid     = 1'b0;
        in_is_branch = 1'b0;
        in_eq        = 1'b0;
        checks++;
        if (br_taken !== 1'b0 || br_target !== 16'h0040 || wb_valid !== 1'b0 || op_count !== exp_cnt) begin
            errors++;
            $display("FAIL br_not_taken: taken=%b target=%h wbv=%b cnt=%0d expected 0/0040/0/%0d",
                     br_taken, br_target, wb_valid, op_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        drive_op(3'd1, 16'h1111, 1'b0, 1'b0, 3'd1, 1'b1);
        step(); exp_cnt++;
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 16'h1111 || wb_rd !== 3'd1) begin
            errors++;
            $display("FAIL bp_latency: valid=%b rd=%0d data=%h expected 1/1/1111", wb_valid, wb_rd, wb_data);
        end
        drive_op(3'd1, 16'h2222, 1'b0, 1'b0, 3'd2, 1'b1);
        step(); exp_cnt++;
        drive_op(3'd1, 16'h3333, 1'b0, 1'b0, 3'd3, 1'b1);
        step();
        checks++;
        if (in_ready !== 1'b0 || op_count !== exp_cnt || wb_data !== 16'h1111 || dbg_count !== 2'd2) begin
            errors++;
            $display("FAIL bp_full: ready=%b cnt=%0d data=%h occ=%0d expected 0/%0d/1111/2",
                     in_ready, op_count, wb_data, dbg_count, exp_cnt);
        end
        // Pop while full: the held op must not be taken on this edge.
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || op_count !== exp_cnt || wb_data !== 16'h2222 || wb_rd !== 3'd2) begin
            errors++;
            $display("FAIL bp_pop: ready=%b cnt=%0d rd=%0d data=%h expected 1/%0d/2/2222",
                     in_ready, op_count, wb_rd, wb_data, exp_cnt);
        end
        step(); exp_cnt++;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || op_count !== exp_cnt) begin
            errors++;
            $display("FAIL bp_third: ready=%b cnt=%0d expected 0/%0d", in_ready, op_count, exp_cnt);
        end
        wb_ready = 1'b1;
        step();
        checks++;
        if (wb_data !== 16'h3333 || wb_rd !== 3'd3 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_order: valid=%b rd=%0d data=%h expected 1/3/3333", wb_valid, wb_rd, wb_data);
        end
        step();
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 16'h3333 || wb_rd !== 3'd3 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty_hold: valid=%b rd=%0d data=%h ready=%b expected 0/3/3333/1",
                     wb_valid, wb_rd, wb_data, in_ready);
        end
    endtask

    task automatic test_concurrent();
        wb_ready = 1'b0;
        drive_op(3'd2, 16'h0100, 1'b1, 1'b0, 3'd5, 1'b1);
        step(); exp_cnt++;
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_result = 16'h0101 + 16'(i);
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== 16'h0100 + 16'(i) || dbg_count !== 2'd1 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL concurrent_%0d: valid=%b data=%h occ=%0d ready=%b expected 1/%h/1/1",
                         i, wb_valid, wb_data, dbg_count, in_ready, 16'h0100 + 16'(i));
            end
            step(); exp_cnt++;
        end
        in_valid = 1'b0;
        checks++;
        if (wb_data !== 16'h010A || wb_valid !== 1'b1 || op_count !== exp_cnt) begin
            errors++;
            $display("FAIL concurrent_tail: valid=%b data=%h cnt=%0d expected 1/010a/%0d",
                     wb_valid, wb_data, op_count, exp_cnt);
        end
        step();
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 16'h010A) begin
            errors++;
            $display("FAIL concurrent_drain: valid=%b data=%h expected 0/010a", wb_valid, wb_data);
        end
    endtask

    task automatic test_reset_midstream();
        wb_ready = 1'b0;
        drive_op(3'd2, 16'hABCD, 1'b1, 1'b1, 3'd6, 1'b1);
        step();
        drive_op(3'd2, 16'h8765, 1'b1, 1'b1, 3'd7, 1'b1);
        step();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 16'h0;
        checks++;
        if (wb_valid !== 1'b0 || flags !== 4'b0000 || op_count !== 16'h0 || in_ready !== 1'b1 || wb_data !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b flags=%b cnt=%0d ready=%b data=%h expected 0/0000/0/1/0000",
                     wb_valid, flags, op_count, in_ready, wb_data);
        end
        step();
        rst_n = 1'b1;
        drive_op(3'd0, 16'h00A5, 1'b0, 1'b0, 3'd3, 1'b1);
        step(); exp_cnt++;
        in_valid = 1'b0;
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 3'd3 || wb_data !== 16'h00A5 || op_count !== exp_cnt) begin
            errors++;
            $display("FAIL post_reset_push: valid=%b rd=%0d data=%h cnt=%0d expected 1/3/00a5/%0d",
                     wb_valid, wb_rd, wb_data, op_count, exp_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        c4_valid = 1'b1;
        for (int i = 0; i < 16; i++) step();
        checks++;
        if (c4_op_count !== 4'd0) begin
            errors++;
            $display("FAIL cnt_wrap16: got %0d expected 0", c4_op_count);
        end
        step();
        c4_valid = 1'b0;
        step();
        checks++;
        if (c4_op_count !== 4'd1) begin
            errors++;
            $display("FAIL cnt_wrap17: got %0d expected 1", c4_op_count);
        end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_branch();
        test_backpressure();
        test_concurrent();
        test_reset_midstream();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-to-writeback stage sitting directly downstream of the 16-bit ALU.
- Captures each ALU result (out, Cout, lt, eq, V) together with the decoded instruction's destination info.
- Updates the architectural status flags and resolves BNE branches.
- Buffers register-file writebacks in a small FIFO so a stalled writeback port does not corrupt in-flight results.

Parameters:
- DEPTH, 2, writeback FIFO entries; must be a power of 2, minimum 2.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a completed ALU operation.
- in_ready  output  1  stage can accept; equals !full, registered-state only, no combinational path from wb_ready.
- in_opcode  input  3  ALU opcode of the operation: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, others reserved.
- in_result  input  16  ALU out.
- in_cout  input  1  ALU Cout.
- in_lt  input  1  ALU lt.
- in_eq  input  1  ALU eq.
- in_v  input  1  ALU V.
- in_rd  input  3  destination register index.
- in_wb_en  input  1  operation writes the register file.
- in_is_branch  input  1  operation is BNE; compare is carried in in_eq.
- in_br_target  input  16  branch target PC.
- wb_valid  output  1  FIFO head valid.
- wb_ready  input  1  register file accepts head.
- wb_rd  output  3  head destination index.
- wb_data  output  16  head data.
- br_taken  output  1  one-cycle registered pulse, branch resolved taken.
- br_target  output  16  registered target, valid while br_taken=1.
- flags  output  4  {N,Z,C,V} status register.
- op_count  output  CNT_W  accepted-operation counter.

Behaviour:
- Accept = in_valid & in_ready at the rising edge. All state updates occur on accept edges only, except FIFO pop.
- Reset (async assert, any time, including mid-transfer):
  - FIFO emptied; wb_valid=0, wb_rd=0, wb_data=0.
  - flags=4'b0000, op_count=0, br_taken=0, br_target=0, in_ready=1.
  - Reset release is sampled synchronously; the first accept is possible on the first edge with rst_n=1.
- Flags, updated on every accepted non-branch op:
  - N=in_result[15].
  - Z=(in_result==16'h0000).
  - C=in_cout and V=in_v only for opcodes 2 and 6; for all other opcodes C and V hold.
  - Reserved opcodes 3/4/5 update N,Z only.
  - Branch ops leave flags unchanged.
- Branch:
  - Accepted op with in_is_branch=1 is never enqueued, regardless of in_wb_en.
  - br_taken=1 for exactly the cycle after accept iff in_eq=0; br_target loads in_br_target on that accept.
  - Not-taken: br_taken=0, br_target holds.
- Writeback FIFO:
  - Push when accept & in_wb_en & !in_is_branch, storing {in_rd,in_result}.
  - Pop when wb_valid & wb_ready.
  - Head data appears on wb_* the cycle after push into an empty FIFO (1-cycle latency). No bypass.
  - Simultaneous push and pop: occupancy unchanged, order preserved. This is allowed at any non-full occupancy.
  - Full: in_ready=0 even if a pop occurs the same cycle. in_ready rises the cycle after the pop.
  - Empty: wb_valid=0; wb_data/wb_rd hold the last popped values.
  - Pointers are log2(DEPTH) bits with an extra wrap bit; full/empty are derived from pointer compare, and wrap-around is seamless.
- op_count: +1 on every accept (including branches and non-writeback ops), wraps 2^CNT_W-1 -> 0.
- Upstream data must be held stable while in_valid=1 & in_ready=0; the stage does not check this.

Test Plan:
- Reset mid-stream: fill FIFO with 2 entries, assert rst_n=0 -> immediately wb_valid=0, flags=0, op_count=0, in_ready=1; after release, first push of rd=3,data=16'h00A5 -> wb_valid=1 next cycle with wb_rd=3, wb_data=16'h00A5.
- Flags: ADD result 16'h0000, cout=1, v=0 -> flags=4'b0110. Then AND result 16'h8000, cout=0 -> flags=4'b1010 (C held). Then SUB result 16'h7FFF, v=1 -> flags=4'b0001.
- Branch: is_branch=1, eq=0, target=16'h0040 -> br_taken=1 for one cycle, br_target=16'h0040, no FIFO push, flags unchanged. Same with eq=1 -> br_taken stays 0.
- Backpressure: wb_ready=0, push 3 ops -> accepts 2, in_ready=0 with third held. Raise wb_ready for one cycle -> pop first entry, in_ready=1 next cycle, third accepted; order of wb_data matches push order.
- Concurrent push/pop at occupancy 1 for 10 cycles with incrementing data -> occupancy stays 1, wb_data sequence increments by 1, no loss across pointer wrap.
- Counter wrap: CNT_W=4, 17 accepts -> op_count=1.
